uart_tx_buffered: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_byte_fifo.sv | 64 ++++++
 rtl/uart_tx_buffered.sv | 146 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter.
// Holds the FSM state encoding, parity modes and frame data width.
package uart_pkg;

   localparam int DATA_BITS = 8;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Parity bit for a data byte under the given mode
   function automatic logic parity_bit(
      input logic [DATA_BITS-1:0] b,
      input int                   mode
   );
      return (^b) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO feeding the UART shifter.
// Occupancy lives in a counter; full/empty come from that count.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = DATA_BITS,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rstN,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage array; reads are qualified by the count so no reset needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally; count moves only on push xor pop
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: single-clock 8N1/8E1/8O1(/2 stop) UART transmitter.
// Bytes enter a small FIFO and are framed back-to-back by the FSM.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter  int CLOCK_RATE = 100_000_000,
   parameter  int BAUD_RATE  = 9600,
   parameter  int FIFO_DEPTH = 4,
   parameter  int PARITY     = 0,
   parameter  int STOP_BITS  = 1,
   localparam int CW         = $clog2(FIFO_DEPTH + 1)
)(
   input  logic                 clk,
   input  logic                 rstN,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 dataValid,
   output logic                 dataReady,
   output logic                 txd,
   output logic                 idle,
   output logic [CW-1:0]        fifoCount
);

   localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
   localparam int BW           = $clog2(CLKS_PER_BIT);

   tx_state_t              r_state;
   logic [BW-1:0]          r_baud;
   logic [2:0]             r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_par;
   logic                   r_txd;

   logic [DATA_BITS-1:0]   w_fifo_data;
   logic [CW-1:0]          w_count;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_wrap;
   logic                   w_last_stop;

   assign w_push    = dataValid && !w_full;
   assign dataReady = !w_full;
   assign fifoCount = w_count;
   assign txd       = r_txd;
   assign idle      = (r_state == ST_IDLE) && w_empty;

   // Bit-time boundary and pop decision for the current cycle
   always_comb begin
      w_wrap      = (r_baud == BW'(CLKS_PER_BIT - 1));
      w_last_stop = (r_state == ST_STOP) && w_wrap &&
                    (r_bit_cnt == 3'(STOP_BITS - 1));
      w_pop       = !w_empty &&
                    ((r_state == ST_IDLE) || w_last_stop);
   end

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rstN    (rstN),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (data),
      .o_data  (w_fifo_data),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Frame FSM with baud counter; txd registered from the current state
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state   <= ST_IDLE;
         r_baud    <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_txd     <= 1'b1;
      end else begin
         if (r_state != ST_IDLE) begin
            r_baud <= w_wrap ? '0 : r_baud + BW'(1);
         end
         unique case (r_state)
            ST_IDLE: begin
               r_txd <= 1'b1;
               if (w_pop) begin
                  r_shift   <= w_fifo_data;
                  r_par     <= parity_bit(w_fifo_data, PARITY);
                  r_bit_cnt <= '0;
                  r_baud    <= '0;
                  r_state   <= ST_START;
               end
            end
            ST_START: begin
               r_txd <= 1'b0;
               if (w_wrap) begin
                  r_bit_cnt <= '0;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               r_txd <= r_shift[0];
               if (w_wrap) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                     r_bit_cnt <= '0;
                     r_state   <= (PARITY != PARITY_NONE) ?
                                  ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               r_txd <= r_par;
               if (w_wrap) begin
                  r_bit_cnt <= '0;
                  r_state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               r_txd <= 1'b1;
               if (w_last_stop) begin
                  r_bit_cnt <= '0;
                  if (w_pop) begin
                     r_shift <= w_fifo_data;
                     r_par   <= parity_bit(w_fifo_data, PARITY);
                     r_state <= ST_START;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else if (w_wrap) begin
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench over four parameter variants.
// Serial monitors decode frames and compare against queued bytes.
module tb_uart_tx_buffered;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [7:0] data = 8'h00;
   logic [3:0] valid_v = 4'h0;
   wire  [3:0] ready_v;
   wire  [3:0] txd_v;
   wire  [3:0] idle_v;
   wire  [2:0] cnt_v [4];

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int last_edge = 0;
   bit mon_en = 1'b1;
   int starts [4][16];
   int nstart [4] = '{default: 0};

   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   logic [8:0] q2 [$];
   logic [8:0] q3 [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_buffered #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000),
      .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rstN(rstN), .data(data), .dataValid(valid_v[0]),
      .dataReady(ready_v[0]), .txd(txd_v[0]), .idle(idle_v[0]),
      .fifoCount(cnt_v[0]));

   uart_tx_buffered #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000),
      .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u1 (
      .clk(clk), .rstN(rstN), .data(data), .dataValid(valid_v[1]),
      .dataReady(ready_v[1]), .txd(txd_v[1]), .idle(idle_v[1]),
      .fifoCount(cnt_v[1]));

   uart_tx_buffered #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000),
      .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u2 (
      .clk(clk), .rstN(rstN), .data(data), .dataValid(valid_v[2]),
      .dataReady(ready_v[2]), .txd(txd_v[2]), .idle(idle_v[2]),
      .fifoCount(cnt_v[2]));

   uart_tx_buffered #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000),
      .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u3 (
      .clk(clk), .rstN(rstN), .data(data), .dataValid(valid_v[3]),
      .dataReady(ready_v[3]), .txd(txd_v[3]), .idle(idle_v[3]),
      .fifoCount(cnt_v[3]));

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic void enq(input int u, input logic [8:0] e);
      case (u)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endfunction

   function automatic bit deq(input int u, output logic [8:0] e);
      e = '0;
      case (u)
         0: begin if (q0.size() == 0) return 0; e = q0.pop_front(); end
         1: begin if (q1.size() == 0) return 0; e = q1.pop_front(); end
         2: begin if (q2.size() == 0) return 0; e = q2.pop_front(); end
         default: begin
            if (q3.size() == 0) return 0;
            e = q3.pop_front();
         end
      endcase
      return 1;
   endfunction

   function automatic int qsize(input int u);
      case (u)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   // Decode serial frames mid-bit and score against the queue
   task automatic mon(input int u, input int par, input int nst);
      logic [7:0] b;
      logic [8:0] e;
      logic       p;
      logic       s0;
      logic       ok_stop;
      int         st;
      forever begin
         do @(negedge clk); while (txd_v[u] !== 1'b0);
         st = cyc;
         repeat (5) @(negedge clk);
         s0 = txd_v[u];
         for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = txd_v[u];
         end
         p = 1'b0;
         if (par != 0) begin
            repeat (10) @(negedge clk);
            p = txd_v[u];
         end
         ok_stop = 1'b1;
         for (int i = 0; i < nst; i++) begin
            repeat (10) @(negedge clk);
            if (txd_v[u] !== 1'b1) ok_stop = 1'b0;
         end
         if (mon_en) begin
            if (nstart[u] < 16) starts[u][nstart[u]] = st;
            nstart[u]++;
            chk($sformatf("start_bit_u%0d", u), s0, 1'b0);
            if (!deq(u, e)) begin
               chk($sformatf("unexpected_frame_u%0d", u), 1, 0);
            end else begin
               chk($sformatf("data_u%0d", u), b, e[7:0]);
               if (par != 0)
                  chk($sformatf("parity_u%0d", u), p, e[8]);
            end
            chk($sformatf("stop_bits_u%0d", u), ok_stop, 1'b1);
         end
      end
   endtask

   initial mon(0, 0, 1);
   initial mon(1, 1, 1);
   initial mon(2, 2, 1);
   initial mon(3, 0, 2);

   task automatic push_byte(input int u, input logic [7:0] b,
                            input logic p, input bit en, input bit hold);
      bit acc;
      int k;
      acc = 1'b0;
      k = 0;
      data = b;
      valid_v[u] = 1'b1;
      while (!acc && k < 2000) begin
         acc = ready_v[u];
         @(posedge clk);
         #1;
         k++;
      end
      last_edge = cyc;
      if (!hold) valid_v[u] = 1'b0;
      if (!acc) chk("push_timeout", 0, 1);
      else if (en) enq(u, {p, b});
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (idle_v !== 4'hF && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", idle_v, 4'hF);
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int s;
      int e1;
      int e6;
      int zeros;

      // reset values while rstN is low
      repeat (3) @(negedge clk);
      chk("rst_txd", txd_v, 4'hF);
      chk("rst_idle", idle_v, 4'hF);
      chk("rst_ready", ready_v, 4'hF);
      for (int u = 0; u < 4; u++) chk("rst_count", cnt_v[u], 0);
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      // latency and 0x55 frame on u0
      s = nstart[0];
      push_byte(0, 8'h55, 1'b0, 1'b1, 1'b0);
      n = last_edge;
      @(negedge clk);
      chk("lat_count_after_push", cnt_v[0], 1);
      chk("lat_txd_n", txd_v[0], 1'b1);
      @(negedge clk);
      chk("lat_count_after_pop", cnt_v[0], 0);
      chk("lat_idle_busy", idle_v[0], 1'b0);
      chk("lat_txd_n1", txd_v[0], 1'b1);
      @(negedge clk);
      chk("lat_txd_n2", txd_v[0], 1'b0);
      repeat (98) @(negedge clk);
      chk("idle_before_stop_end", idle_v[0], 1'b0);
      repeat (2) @(negedge clk);
      chk("idle_after_stop", idle_v[0], 1'b1);
      wait_idle();
      chk("latency_edges", starts[0][s] - n, 2);

      // parity variants, back-to-back pairs
      s = nstart[1];
      push_byte(1, 8'hA5, 1'b0, 1'b1, 1'b1);
      push_byte(1, 8'h07, 1'b1, 1'b1, 1'b0);
      push_byte(2, 8'hA5, 1'b1, 1'b1, 1'b1);
      push_byte(2, 8'h07, 1'b0, 1'b1, 1'b0);
      push_byte(3, 8'h3C, 1'b0, 1'b1, 1'b1);
      push_byte(3, 8'hC3, 1'b0, 1'b1, 1'b0);
      wait_idle();
      chk("even_frame_len", starts[1][s+1] - starts[1][s], 110);
      chk("odd_frame_len", starts[2][1] - starts[2][0], 110);
      chk("stop2_frame_len", starts[3][1] - starts[3][0], 110);

      // six bytes with dataValid held, FIFO fills
      s = nstart[0];
      e1 = 0;
      e6 = 0;
      for (int b = 1; b <= 6; b++) begin
         push_byte(0, 8'(b), 1'b0, 1'b1, b != 6);
         if (b == 1) e1 = last_edge;
         if (b == 6) e6 = last_edge;
         if (b == 5) begin
            chk("full_ready_low", ready_v[0], 1'b0);
            chk("full_count", cnt_v[0], 4);
         end
      end
      chk("sixth_accept_edge", e6 - e1, 102);
      wait_idle();
      for (int k = 1; k < 6; k++)
         chk("contig_start", starts[0][s+k] - starts[0][s+k-1], 100);

      // push and pop on the same edge at count 2
      push_byte(0, 8'h11, 1'b0, 1'b1, 1'b1);
      n = last_edge;
      push_byte(0, 8'h22, 1'b0, 1'b1, 1'b1);
      push_byte(0, 8'h33, 1'b0, 1'b1, 1'b0);
      chk("pp_count_pre", cnt_v[0], 2);
      while (cyc < n + 100) begin
         @(posedge clk);
         #1;
      end
      chk("pp_count_before", cnt_v[0], 2);
      data = 8'h44;
      valid_v[0] = 1'b1;
      @(posedge clk);
      #1;
      valid_v[0] = 1'b0;
      enq(0, {1'b0, 8'h44});
      chk("pp_count_after", cnt_v[0], 2);
      chk("pp_ready_after", ready_v[0], 1'b1);
      wait_idle();
      for (int u = 0; u < 4; u++) chk("queue_drained", qsize(u), 0);

      // asynchronous reset in the middle of a frame
      mon_en = 1'b0;
      push_byte(0, 8'h00, 1'b0, 1'b0, 1'b0);
      n = last_edge;
      while (cyc < n + 42) begin
         @(posedge clk);
         #1;
      end
      chk("abort_mid_low", txd_v[0], 1'b0);
      rstN = 1'b0;
      #1;
      chk("abort_txd", txd_v[0], 1'b1);
      chk("abort_count", cnt_v[0], 0);
      chk("abort_idle", idle_v[0], 1'b1);
      chk("abort_ready", ready_v[0], 1'b1);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      zeros = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (txd_v[0] !== 1'b1) zeros++;
      end
      chk("no_start_after_reset", zeros, 0);
      chk("post_reset_idle", idle_v[0], 1'b1);
      chk("post_reset_count", cnt_v[0], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
